vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator; successor to the fixed 640x480 generator. Horizontal and vertical active, front-porch, sync and back-porch lengths, sync polarity and counter width are all set by parameters. Adds a pixel-clock enable, an explicit per-axis phase state machine, and frame/line start strobes. Sits between the pixel clock domain and the pixel/sprite renderers, which consume `xCount`/`yCount`/`displayArea`.

---
 rtl/vga_timing_gen_if.sv | 30 +++
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator (master) and the
// pixel/sprite renderers (slave).
interface vga_timing_gen_if #(
    parameter int CNT_W = 10
);
    logic             pix_en;
    logic [CNT_W-1:0] xCount;
    logic [CNT_W-1:0] yCount;
    logic             displayArea;
    logic             blank_n;
    logic             VGA_hSync;
    logic             VGA_vSync;
    logic             vblank;
    logic [1:0]       h_phase;
    logic [1:0]       v_phase;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  pix_en,
        output xCount, yCount, displayArea, blank_n, VGA_hSync, VGA_vSync,
               vblank, h_phase, v_phase, line_start, frame_start
    );

    modport slave (
        output pix_en,
        input  xCount, yCount, displayArea, blank_n, VGA_hSync, VGA_vSync,
               vblank, h_phase, v_phase, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: x/y counters, per-axis phase FSMs,
// sync/blank decode and line/frame start strobes, all registered together.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CNT_W      = 10
) (
    input  logic                     VGA_clk,
    input  logic                     VGA_rst,
    vga_timing_gen_if.master         io_vga
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_FRONT_AT = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_AT  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_BACK_AT  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_FRONT_AT = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_AT  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_BACK_AT  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (CNT_W < 1 || (64'd1 << CNT_W) < 64'(MAX_TOTAL)) begin : g_cnt_w_check
            $error("vga_timing_gen: CNT_W too narrow for the raster totals");
        end
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_len_check
            $error("vga_timing_gen: active/porch/sync lengths must be non-zero");
        end
    endgenerate

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    logic [CNT_W-1:0] r_x, r_y;
    phase_e           r_h_phase, r_v_phase;
    logic             r_disp, r_vblank, r_hsync, r_vsync;
    logic             r_line_start, r_frame_start;

    logic [CNT_W-1:0] w_x_nxt, w_y_nxt;
    phase_e           w_h_nxt, w_v_nxt;
    logic             w_x_last, w_y_last, w_h_wrap, w_v_wrap;

    // Phase advances on entry to the first count of the next region.
    function automatic phase_e next_phase(
        input phase_e           cur,
        input logic             adv,
        input logic [CNT_W-1:0] nxt,
        input logic [CNT_W-1:0] front_at,
        input logic [CNT_W-1:0] sync_at,
        input logic [CNT_W-1:0] back_at
    );
        phase_e ph;
        ph = cur;
        if (adv) begin
            case (cur)
                PH_ACTIVE: if (nxt == front_at) ph = PH_FRONT;
                PH_FRONT:  if (nxt == sync_at)  ph = PH_SYNC;
                PH_SYNC:   if (nxt == back_at)  ph = PH_BACK;
                PH_BACK:   if (nxt == '0)       ph = PH_ACTIVE;
            endcase
        end
        return ph;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so this block never infers a latch.
        w_x_last = (r_x == H_LAST);
        w_y_last = (r_y == V_LAST);
        w_h_wrap = io_vga.pix_en && w_x_last;
        w_v_wrap = w_h_wrap && w_y_last;
        w_x_nxt  = r_x;
        w_y_nxt  = r_y;
        if (io_vga.pix_en) begin
            w_x_nxt = w_x_last ? '0 : r_x + CNT_W'(1);
        end
        if (w_h_wrap) begin
            w_y_nxt = w_y_last ? '0 : r_y + CNT_W'(1);
        end
        w_h_nxt = next_phase(r_h_phase, io_vga.pix_en, w_x_nxt,
                             H_FRONT_AT, H_SYNC_AT, H_BACK_AT);
        w_v_nxt = next_phase(r_v_phase, w_h_wrap, w_y_nxt,
                             V_FRONT_AT, V_SYNC_AT, V_BACK_AT);
    end

    // Decode is taken from the next-state values so it lines up with the counters.
    always_ff @(posedge VGA_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (VGA_rst) begin
            r_x           <= H_LAST;
            r_y           <= V_LAST;
            r_h_phase     <= PH_BACK;
            r_v_phase     <= PH_BACK;
            r_disp        <= 1'b0;
            r_vblank      <= 1'b1;
            r_hsync       <= ~H_SYNC_POL;
            r_vsync       <= ~V_SYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_h_phase     <= w_h_nxt;
            r_v_phase     <= w_v_nxt;
            r_disp        <= (w_h_nxt == PH_ACTIVE) && (w_v_nxt == PH_ACTIVE);
            r_vblank      <= (w_v_nxt != PH_ACTIVE);
            r_hsync       <= (w_h_nxt == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            r_vsync       <= (w_v_nxt == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

    assign io_vga.xCount      = r_x;
    assign io_vga.yCount      = r_y;
    assign io_vga.h_phase     = r_h_phase;
    assign io_vga.v_phase     = r_v_phase;
    assign io_vga.displayArea = r_disp;
    assign io_vga.blank_n     = r_disp;
    assign io_vga.vblank      = r_vblank;
    assign io_vga.VGA_hSync   = r_hsync;
    assign io_vga.VGA_vSync   = r_vsync;
    assign io_vga.line_start  = r_line_start;
    assign io_vga.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default 640x480 instance and a tiny
// 4/1/1/1 x 2/1/1/1 instance with positive sync polarity.
module tb_vga_timing_gen;
    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;

    typedef struct {
        bit    sel;
        int    x;
        int    y;
        bit    disp;
        bit    hs;
        bit    vs;
        bit    vb;
        int    hph;
        int    vph;
        bit    ls;
        bit    fs;
        string tag;
    } exp_t;

    exp_t q[$];
    int   fs_t[$];

    int HT[2] = '{800, 7};
    int VT[2] = '{525, 5};
    int bx[2];
    int by[2];

    vga_timing_gen_if #(.CNT_W(10)) d_if ();
    vga_timing_gen_if #(.CNT_W(3))  s_if ();

    vga_timing_gen u_big (
        .VGA_clk (clk),
        .VGA_rst (rst),
        .io_vga  (d_if)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(3)
    ) u_small (
        .VGA_clk (clk),
        .VGA_rst (rst),
        .io_vga  (s_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected decode from absolute position, using region boundaries only.
    function automatic exp_t model(input bit sel, input int x, input int y,
                                   input bit ls, input bit fs, input string tag);
        exp_t e;
        int   ha, hf, hsw, va, vf, vsw;
        bit   hp, vp;
        if (sel) begin
            ha = 4;   hf = 1;  hsw = 1;  va = 2;   vf = 1;  vsw = 1; hp = 1'b1; vp = 1'b1;
        end else begin
            ha = 640; hf = 16; hsw = 96; va = 480; vf = 10; vsw = 2; hp = 1'b0; vp = 1'b0;
        end
        e.sel  = sel;
        e.x    = x;
        e.y    = y;
        e.hph  = (x < ha) ? 0 : (x < ha + hf) ? 1 : (x < ha + hf + hsw) ? 2 : 3;
        e.vph  = (y < va) ? 0 : (y < va + vf) ? 1 : (y < va + vf + vsw) ? 2 : 3;
        e.disp = (e.hph == 0) && (e.vph == 0);
        e.vb   = (e.vph != 0);
        e.hs   = (e.hph == 2) ? hp : !hp;
        e.vs   = (e.vph == 2) ? vp : !vp;
        e.ls   = ls;
        e.fs   = fs;
        e.tag  = tag;
        return e;
    endfunction

    function automatic exp_t lit(input bit sel, input int x, input int y, input bit disp,
                                 input bit hs, input bit vs, input bit vb, input int hph,
                                 input int vph, input bit ls, input bit fs, input string tag);
        exp_t e;
        e.sel = sel; e.x = x; e.y = y; e.disp = disp; e.hs = hs; e.vs = vs; e.vb = vb;
        e.hph = hph; e.vph = vph; e.ls = ls; e.fs = fs; e.tag = tag;
        return e;
    endfunction

    // Drives one edge and tracks where the selected raster should land.
    task automatic drive_edge(input bit sel, input bit r, input bit en,
                              output bit ls, output bit fs);
        rst       = r;
        d_if.pix_en = !sel && en;
        s_if.pix_en = sel && en;
        @(posedge clk);
        ls = 1'b0;
        fs = 1'b0;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                bx[k] = HT[k] - 1;
                by[k] = VT[k] - 1;
            end
        end else if (en) begin
            ls = (bx[sel] == HT[sel] - 1);
            fs = ls && (by[sel] == VT[sel] - 1);
            bx[sel] = ls ? 0 : bx[sel] + 1;
            if (ls) by[sel] = fs ? 0 : by[sel] + 1;
        end
    endtask

    task automatic step(input bit sel, input bit r, input bit en, input bit chk, input string tag);
        bit ls, fs;
        drive_edge(sel, r, en, ls, fs);
        if (chk) q.push_back(model(sel, bx[sel], by[sel], ls, fs, tag));
        #1;
    endtask

    task automatic step_lit(input bit sel, input bit r, input bit en, input exp_t e);
        bit ls, fs;
        drive_edge(sel, r, en, ls, fs);
        q.push_back(e);
        #1;
    endtask

    // Monitor: one registered output set per clock, compared away from the edge.
    initial begin
        exp_t e;
        int   ax, ay, aflags, aph, eflags, eph;
        forever begin
            @(negedge clk);
            if (s_if.frame_start) fs_t.push_back(cyc);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel) begin
                    ax     = int'(s_if.xCount);
                    ay     = int'(s_if.yCount);
                    aflags = int'({s_if.displayArea, s_if.blank_n, s_if.VGA_hSync, s_if.VGA_vSync,
                                   s_if.vblank, s_if.line_start, s_if.frame_start});
                    aph    = int'({s_if.h_phase, s_if.v_phase});
                end else begin
                    ax     = int'(d_if.xCount);
                    ay     = int'(d_if.yCount);
                    aflags = int'({d_if.displayArea, d_if.blank_n, d_if.VGA_hSync, d_if.VGA_vSync,
                                   d_if.vblank, d_if.line_start, d_if.frame_start});
                    aph    = int'({d_if.h_phase, d_if.v_phase});
                end
                eflags = int'({e.disp, e.disp, e.hs, e.vs, e.vb, e.ls, e.fs});
                eph    = e.hph * 4 + e.vph;
                check({e.tag, " xCount"}, ax, e.x);
                check({e.tag, " yCount"}, ay, e.y);
                check({e.tag, " flags{disp,blank_n,hs,vs,vblank,ls,fs}"}, aflags, eflags);
                check({e.tag, " phases{h,v}"}, aph, eph);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        d_if.pix_en = 1'b0;
        s_if.pix_en = 1'b0;
        bx[0] = 0; by[0] = 0; bx[1] = 0; by[1] = 0;

        // Reset with pix_en high: reset wins.
        step_lit(0, 1, 1, lit(0, 799, 524, 0, 1, 1, 1, 3, 3, 0, 0, "big reset"));
        step_lit(1, 1, 1, lit(1, 6, 4, 0, 0, 0, 1, 3, 3, 0, 0, "small reset"));
        step_lit(0, 1, 1, lit(0, 799, 524, 0, 1, 1, 1, 3, 3, 0, 0, "big reset hold"));

        // First line of the default raster, with hand-computed boundary vectors.
        step_lit(0, 0, 1, lit(0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, "first edge"));
        step_lit(0, 0, 1, lit(0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, "second edge"));
        for (int i = 2; i < 800; i++) begin
            case (i)
                640:     step_lit(0, 0, 1, lit(0, 640, 0, 0, 1, 1, 0, 1, 0, 0, 0, "x=640 front"));
                656:     step_lit(0, 0, 1, lit(0, 656, 0, 0, 0, 1, 0, 2, 0, 0, 0, "x=656 hsync"));
                752:     step_lit(0, 0, 1, lit(0, 752, 0, 0, 1, 1, 0, 3, 0, 0, 0, "x=752 back"));
                default: step(0, 0, 1, 1, "line0");
            endcase
        end

        // Run to (799,10) and check the line wrap.
        for (int i = 0; i < 10 * 800; i++) step(0, 0, 1, 0, "");
        step_lit(0, 0, 1, lit(0, 0, 11, 1, 1, 1, 0, 0, 0, 1, 0, "wrap to (0,11)"));
        step(0, 0, 1, 1, "after wrap");

        // Reset in the middle of hSync.
        for (int i = 0; i < 698; i++) step(0, 0, 1, 0, "");
        step(0, 0, 1, 1, "x=700 in hsync");
        step_lit(0, 1, 1, lit(0, 799, 524, 0, 1, 1, 1, 3, 3, 0, 0, "mid-frame reset"));
        step(0, 1, 1, 1, "mid-frame reset hold");
        step_lit(0, 0, 1, lit(0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, "re-release first edge"));
        step_lit(0, 0, 1, lit(0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, "re-release second edge"));

        // Small raster: three continuous frames, every cycle against the model.
        @(negedge clk);
        #1;
        fs_t.delete();
        step_lit(1, 0, 1, lit(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "small first edge"));
        for (int i = 1; i < 105; i++) step(1, 0, 1, 1, "small run");
        @(negedge clk);
        #1;
        check("small frame_start count", fs_t.size(), 3);
        if (fs_t.size() == 3) begin
            check("small frame spacing 1", fs_t[1] - fs_t[0], 35);
            check("small frame spacing 2", fs_t[2] - fs_t[1], 35);
        end
        fs_t.delete();

        // pix_en on every other clock: half rate, strobes still one clock wide.
        for (int i = 0; i < 210; i++) step(1, 0, (i % 2) == 0, 1, "small half rate");
        @(negedge clk);
        #1;
        check("half-rate frame_start count", fs_t.size(), 3);
        if (fs_t.size() == 3) begin
            check("half-rate frame spacing 1", fs_t[1] - fs_t[0], 70);
            check("half-rate frame spacing 2", fs_t[2] - fs_t[1], 70);
        end

        @(negedge clk);
        #1;
        check("scoreboard drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
